// File: rtl/seg7_reader.sv
// seg7_reader: debounces multiplexed 7-segment scan lines and rebuilds a 4-digit BCD frame.
module seg7_reader #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [0:6]  seg,
    input  logic [3:0]  dig_sel,
    output logic [15:0] bcd,
    output logic [3:0]  blank,
    output logic        err,
    output logic        frame_valid
);
    localparam logic SETTLE  = 1'b0;
    localparam logic LATCHED = 1'b1;
    logic [10:0] smp;
    logic        state;
    logic [7:0]  cnt;
    logic [15:0] sh_bcd, nx_bcd;
    logic [3:0]  sh_blank, sh_inv, seen, nx_blank, nx_inv, nx_seen, nib;
    logic        change, one_hot, done, accept;
    always_comb begin
        case (seg)
            7'b1111110: nib = 4'd0;
            7'b0110000: nib = 4'd1;
            7'b1101101: nib = 4'd2;
            7'b1111001: nib = 4'd3;
            7'b0110011: nib = 4'd4;
            7'b1011011: nib = 4'd5;
            7'b1011111: nib = 4'd6;
            7'b1110000: nib = 4'd7;
            7'b1111111: nib = 4'd8;
            7'b1111011: nib = 4'd9;
            7'b0000000: nib = 4'hA;
            default:    nib = 4'hF;
        endcase
    end
    assign change  = {dig_sel, seg} != smp;
    assign one_hot = dig_sel != 4'd0 && (dig_sel & (dig_sel - 4'd1)) == 4'd0;
    assign done    = !change && state == SETTLE && cnt + 8'd1 == 8'(STABLE_CYCLES);
    assign accept  = done && one_hot;
    assign nx_seen = seen | dig_sel;
    always_comb begin
        nx_bcd   = sh_bcd;
        nx_blank = sh_blank;
        nx_inv   = sh_inv;
        for (int i = 0; i < 4; i++) begin
            if (dig_sel[i]) begin
                nx_bcd[4*i+:4] = nib;
                nx_blank[i]    = nib == 4'hA;
                nx_inv[i]      = nib == 4'hF;
            end
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            smp         <= '0;
            state       <= SETTLE;
            cnt         <= '0;
            sh_bcd      <= '0;
            sh_blank    <= '0;
            sh_inv      <= '0;
            seen        <= '0;
            bcd         <= '0;
            blank       <= '0;
            err         <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            smp         <= {dig_sel, seg};
            frame_valid <= 1'b0;
            if (change) begin
                cnt   <= 8'd1;
                state <= SETTLE;
            end else if (state == SETTLE) begin
                cnt <= cnt + 8'd1;
                if (done) state <= LATCHED;
            end
            if (accept) begin
                sh_bcd   <= nx_bcd;
                sh_blank <= nx_blank;
                sh_inv   <= nx_inv;
                // the just-accepted digit completes the frame on this same edge
                if (&nx_seen) begin
                    bcd         <= nx_bcd;
                    blank       <= nx_blank;
                    err         <= |nx_inv;
                    frame_valid <= 1'b1;
                    seen        <= '0;
                end else begin
                    seen <= nx_seen;
                end
            end
        end
    end
endmodule

// File: doc/seg7_reader.md
SEG7_READER -- requirements
Module: seg7_reader

Interface
REQ-001 Parameter STABLE_CYCLES, default 4: consecutive clock edges a (dig_sel, seg) sample must be held before acceptance; legal range 2..255.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 seg  input  [0:6]  segment lines, seg[0]=a .. seg[6]=g, 1 = segment lit; same encoding the decoder drives.
REQ-005 dig_sel  input  [3:0]  one-hot digit strobe of a multiplexed 4-digit display; bit i = digit i (digit 0 = least significant).
REQ-006 bcd  output  [15:0]  last complete frame, digit i in bcd[4i+3:4i]; 4'hA = blank digit, 4'hF = invalid pattern.
REQ-007 blank  output  [3:0]  bit i set when digit i of the last frame was all-segments-off.
REQ-008 err  output  1  set when the last frame contained at least one invalid pattern.
REQ-009 frame_valid  output  1  one-cycle pulse marking update of bcd/blank/err.

Function
REQ-010 Pattern table (seg[0:6]) SHALL be: 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000, 8=1111111, 9=1111011, blank=0000000; any other pattern decodes to 4'hF.
REQ-011 Sample register SHALL hold {dig_sel, seg} from the previous edge; "change" = current inputs differ from it.
REQ-012 Settle FSM SHALL have states SETTLE and LATCHED plus a stability counter cnt (8 bits).
REQ-013 Any edge with a change: cnt <= 1, state <= SETTLE, regardless of current state.
REQ-014 SETTLE, no change: cnt increments; on the edge where cnt reaches STABLE_CYCLES the sample is accepted and state <= LATCHED.
REQ-015 LATCHED, no change: no action; a held pattern SHALL be accepted exactly once.
REQ-016 Acceptance with dig_sel not one-hot (zero or multiple bits): sample discarded, no shadow/mask update.
REQ-017 Acceptance with one-hot dig_sel bit i: shadow digit i <= decoded nibble, shadow blank/invalid flags i updated, seen[i] <= 1; re-acceptance of a digit already seen overwrites it.
REQ-018 When an acceptance makes seen == 4'b1111: on that same edge bcd, blank, err <= shadow values (including the just-accepted digit), frame_valid <= 1, seen <= 0.
REQ-019 frame_valid SHALL be 0 on every other edge; bcd/blank/err SHALL hold between frames.
REQ-020 Latency: input held from edge N onward, accepted on edge N+STABLE_CYCLES-1 (counting the change edge as N); frame outputs visible after that same edge.
REQ-021 A change during SETTLE before acceptance SHALL abort that sample with no side effects.
REQ-022 Digits may arrive in any order; no timeout; partial frames persist until completed or reset.

Reset
REQ-023 rst asserted SHALL immediately force: bcd=16'h0000, blank=4'b0000, err=0, frame_valid=0, seen=0, shadow=0, sample register=0, cnt=0, state=SETTLE.
REQ-024 Reset mid-frame SHALL discard the partial frame; first frame after reset requires all four digits anew.
REQ-025 After rst deasserts, inputs unequal to zero count as a change on the first edge.

Verification
REQ-026 Digits 3,2,1,0 shown as patterns 9,4,0,7, each held 6 cycles, STABLE_CYCLES=4 -> one frame_valid pulse, bcd=16'h9407, blank=0, err=0.
REQ-027 Digit 1 held 3 cycles only (glitch) within an otherwise full scan -> no frame_valid until digit 1 is held >=4 cycles; then bcd reflects new value.
REQ-028 Digit 2 shows 0000000, digit 0 shows 1000001 -> bcd=16'h?A?F pattern (digit2=A, digit0=F), blank=4'b0100, err=1.
REQ-029 Digit 0 held 40 cycles after frame completion -> accepted once, no second frame_valid from the hold.
REQ-030 dig_sel=4'b0011 held 10 cycles -> no shadow update, seen unchanged, no frame_valid.
REQ-031 rst pulsed after three digits accepted -> outputs return to reset values asynchronously; next frame_valid only after four fresh digits.
